aes_key_schedule: RTL and testbench
===================================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 Parameter KEY_BITS, default 128: cipher key length; legal values 128, 192, 256; any other value SHALL stop elaboration with an error.
REQ-002 Derived constants SHALL be NK = KEY_BITS/32 (4/6/8), NR = NK+6 (10/12/14), NW = 4*(NR+1) (44/52/60).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 key_in  input  KEY_BITS  cipher key; word w0 is bits [KEY_BITS-1:KEY_BITS-32].
REQ-006 key_valid  input  1  key_in is offered.
REQ-007 key_ready  output  1  block is idle and accepts a key.
REQ-008 rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in the MSBs.
REQ-009 rk_round  output  4  index r of rk_out, 0..NR.
REQ-010 rk_last  output  1  high when rk_round == NR.
REQ-011 rk_valid  output  1  rk_out/rk_round/rk_last are valid.
REQ-012 rk_ready  input  1  consumer accepts the round key.

Function
REQ-013 Key acceptance SHALL occur on a rising edge with key_valid && key_ready; key_in SHALL be captured at that edge, and key_ready SHALL be low from the next cycle until the rk_last transfer.
REQ-014 key_valid while key_ready is low SHALL be ignored, with no effect on the schedule in progress.
REQ-015 The FSM SHALL have states IDLE (key_ready=1), GEN (produce one word), SUB (wait one cycle for the registered S4 word substitution), and DRAIN (all NW words produced, waiting for the final transfer).
REQ-016 Words SHALL be produced in order w0..w[NW-1]; for j < NK, w[j] is the captured key word, produced in 1 GEN cycle.
REQ-017 For j >= NK with t = w[j-1], words SHALL follow FIPS-197: if j mod NK == 0, w[j] = w[j-NK] ^ SubWord(RotWord(t)) ^ {rcon,24'h0}; if NK == 8 and j mod 8 == 4, w[j] = w[j-NK] ^ SubWord(t); otherwise w[j] = w[j-NK] ^ t.
REQ-018 A word needing SubWord SHALL take exactly 2 cycles (GEN->SUB->GEN); all other words SHALL take exactly 1 cycle.
REQ-019 SubWord SHALL use the team's S4 4-byte S-box block, with one-cycle registered latency.
REQ-020 rcon SHALL start at 8'h01 on key acceptance and advance by GF(2^8) xtime (poly 8'h1b) after each use: 01,02,04,08,10,20,40,80,1b,36.
REQ-021 Only an NK-word sliding window of w SHALL be stored; no full-schedule RAM.
REQ-022 Produced words SHALL fill a 4-word assembly register; on the 4th word, the assembly SHALL move to the output register at the next edge when the output register is empty or is being transferred that edge.
REQ-023 If the assembly is full and cannot move, word production SHALL stall (FSM holds state, window and rcon unchanged) until it can move.
REQ-024 rk_valid, once high, SHALL stay high with rk_out/rk_round stable until a rising edge with rk_valid && rk_ready.
REQ-025 rk_round SHALL increment by 1 per transfer, starting at 0.
REQ-026 After the transfer with rk_last=1, the FSM SHALL return to IDLE and key_ready SHALL be high the next cycle.
REQ-027 A transfer and a new assembly arriving in the same cycle SHALL lose neither key.
REQ-028 With rk_ready held high, KEY_BITS=128 round 0 SHALL present rk_valid 5 cycles after acceptance, and each round SHALL take 5 cycles after that (4 words, 1 with SubWord).

Reset
REQ-029 While rst is low: key_ready=0, rk_valid=0, rk_last=0, rk_round=0, rk_out=128'h0, FSM=IDLE, rcon=8'h01, window and assembly cleared.
REQ-030 After rst deasserts, key_ready SHALL be 1 from the first rising edge.
REQ-031 Reset asserted mid-schedule SHALL abort the schedule; no stale round key SHALL appear after release.

Verification
REQ-032 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rounds 0..10; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1; round 0 rk_valid exactly 5 cycles after acceptance.
REQ-033 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 round keys; round 12 = e98ba06f448c773c8ecc720401002202.
REQ-034 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 round keys; round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-035 KEY_BITS=128, rk_ready randomly low about 50% -> same 11 keys in order; rk_out stable while stalled; key_valid pulses during the schedule are ignored.
REQ-036 KEY_BITS=128, rst pulled low after round 3 transfers, then second key 000102030405060708090a0b0c0d0e0f -> outputs at reset values; new schedule starts at round 0; round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-037 Back-to-back keys -> key_ready rises exactly one cycle after the rk_last transfer; second key accepted that cycle.

Source files
------------

// File: rtl/aes_key_schedule.sv
// AES key expansion: streams round keys 0..NR as 128-bit words; 4-5 cycles per round, 2 cycles per SubWord word.
// Backpressure: a full assembly that cannot reach the output register freezes word production until rk_ready frees it.

module aes_s4 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  output logic [31:0] q
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 32'h0;
    else      q <= {sbox(d[31:24]), sbox(d[23:16]), sbox(d[15:8]), sbox(d[7:0])};
  end
endmodule

module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic [127:0]        rk_out,
  output logic [3:0]          rk_round,
  output logic                rk_last,
  output logic                rk_valid,
  input  logic                rk_ready
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GEN, SUB, DRAIN} state_t;

  state_t       state;
  logic [31:0]  win [NK];
  logic [5:0]   widx;
  logic [2:0]   pos;
  logic [7:0]   rcon;
  logic [127:0] asm_dat;
  logic [2:0]   asm_cnt;

  logic         first, rot, need_sub, last_word;
  logic         asm_full, out_xfer, asm_move, stall, word_we;
  logic [31:0]  s4_d, s4_q, word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // win[0] is always w[j-NK] and win[NK-1] is w[j-1]; while the key words are
  // replayed the window rotates, so it holds w0..w[NK-1] again once they are out.
  assign first     = widx < 6'(NK);
  assign rot       = pos == 3'd0;
  assign need_sub  = !first && (rot || (NK == 8 && pos == 3'd4));
  assign last_word = widx == 6'(NW - 1);
  assign s4_d      = rot ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];

  assign asm_full  = asm_cnt == 3'd4;
  assign out_xfer  = rk_valid && rk_ready;
  assign asm_move  = asm_full && (!rk_valid || out_xfer);
  assign stall     = asm_full && !asm_move;
  assign rk_last   = rk_round == 4'(NR);

  aes_s4 u_s4 (
    .clk (clk),
    .rst (rst),
    .d   (s4_d),
    .q   (s4_q)
  );

  always_comb begin
    word    = first ? win[0] : (win[0] ^ win[NK-1]);
    word_we = 1'b0;
    if (!stall) begin
      if (state == GEN && !need_sub) begin
        word_we = 1'b1;
      end else if (state == SUB) begin
        word_we = 1'b1;
        word    = win[0] ^ s4_q ^ (rot ? {rcon, 24'h0} : 32'h0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      widx      <= 6'd0;
      pos       <= 3'd0;
      rcon      <= 8'h01;
      asm_dat   <= 128'h0;
      asm_cnt   <= 3'd0;
      rk_out    <= 128'h0;
      rk_round  <= 4'd0;
      rk_valid  <= 1'b0;
      for (int i = 0; i < NK; i++) win[i] <= 32'h0;
    end else begin
      if (asm_move) begin
        rk_out   <= asm_dat;
        rk_valid <= 1'b1;
      end else if (out_xfer) begin
        rk_valid <= 1'b0;
      end
      if (out_xfer) rk_round <= rk_last ? 4'd0 : rk_round + 4'd1;

      if (word_we) asm_dat <= {asm_dat[95:0], word};
      if (asm_move)     asm_cnt <= word_we ? 3'd1 : 3'd0;
      else if (word_we) asm_cnt <= asm_cnt + 3'd1;

      if (word_we) begin
        for (int i = 0; i < NK - 1; i++) win[i] <= win[i+1];
        win[NK-1] <= word;
        widx      <= widx + 6'd1;
        pos       <= (pos == 3'(NK - 1)) ? 3'd0 : pos + 3'd1;
        if (state == SUB && rot) rcon <= xtime(rcon);
      end

      case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
            state     <= GEN;
            key_ready <= 1'b0;
            widx      <= 6'd0;
            pos       <= 3'd0;
            rcon      <= 8'h01;
            for (int i = 0; i < NK; i++) win[i] <= key_in[KEY_BITS-1-32*i -: 32];
          end else begin
            key_ready <= 1'b1;
          end
        end
        GEN: begin
          if (!stall && need_sub)      state <= SUB;
          else if (word_we && last_word) state <= DRAIN;
        end
        SUB: begin
          if (word_we) state <= last_word ? DRAIN : GEN;
        end
        DRAIN: begin
          if (out_xfer && rk_last) begin
            state     <= IDLE;
            key_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule at 128/192/256-bit keys; expected round keys
// come from a word-by-word FIPS-197 expansion with a table S-box built by the bench.

module tb_aes_key_schedule;
  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   rd;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic [127:0] key_in_a;
  logic [191:0] key_in_b;
  logic [255:0] key_in_c;
  logic kv_a, kv_b, kv_c, kr_a, kr_b, kr_c;
  logic rv_a, rv_b, rv_c, rr_a, rr_b, rr_c;
  logic last_a, last_b, last_c;
  logic [127:0] rk_a, rk_b, rk_c;
  logic [3:0] rd_a, rd_b, rd_c;

  aes_key_schedule #(.KEY_BITS(128)) u_a (.clk(clk), .rst(rst), .key_in(key_in_a), .key_valid(kv_a),
    .key_ready(kr_a), .rk_out(rk_a), .rk_round(rd_a), .rk_last(last_a), .rk_valid(rv_a), .rk_ready(rr_a));
  aes_key_schedule #(.KEY_BITS(192)) u_b (.clk(clk), .rst(rst), .key_in(key_in_b), .key_valid(kv_b),
    .key_ready(kr_b), .rk_out(rk_b), .rk_round(rd_b), .rk_last(last_b), .rk_valid(rv_b), .rk_ready(rr_b));
  aes_key_schedule #(.KEY_BITS(256)) u_c (.clk(clk), .rst(rst), .key_in(key_in_c), .key_valid(kv_c),
    .key_ready(kr_c), .rk_out(rk_c), .rk_round(rd_c), .rk_last(last_c), .rk_valid(rv_c), .rk_ready(rr_c));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  logic [127:0] got_a [16];
  logic [127:0] got_b [16];
  logic [127:0] got_c [16];
  logic [7:0] sbox_t [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  int n_acc_a = 0;   // keys accepted by u_a (stimulus side)
  int n_last_a = 0;  // schedules finished or aborted (monitor side)
  int r0_done = 0;
  int nxfer_a = 0;
  int acc_cyc = 0;
  bit hold_v = 0;
  bit kr_pend = 0;
  logic [127:0] hold_rk;
  logic [3:0] hold_rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Walk p over all nonzero elements by x3 while q tracks its inverse by /3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Full expansion; key is right-aligned, w0 in its top word.
  task automatic model_push(input int nk, input logic [255:0] key, input int which);
    logic [31:0] w [60];
    logic [31:0] t;
    exp_t e;
    int nr;
    int nw;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = key[32*(nk-1-i) +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      e.rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.rd = 4'(r);
      e.last = (r == nr);
      case (which)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 0;
      kr_pend = 0;
      n_last_a = n_acc_a;
      r0_done = n_acc_a;
    end else begin
      if (kr_pend) chk("key_ready_after_last", kr_a, 1);
      kr_pend = 0;
      if (n_last_a != n_acc_a) chk("key_ready_busy", kr_a, 0);
      if (hold_v) begin
        chk("rk_valid_hold", rv_a, 1);
        chk("rk_out_hold", rk_a, hold_rk);
        chk("rk_round_hold", rd_a, hold_rd);
      end
      hold_v = rv_a && !rr_a;
      hold_rk = rk_a;
      hold_rd = rd_a;
      if (r0_done != n_acc_a && rv_a) begin
        chk("round0_latency", cyc - acc_cyc, 5);
        r0_done = n_acc_a;
      end
      if (rv_a && rr_a) begin
        if (qa.size() == 0) fail_now("unexpected_rk_a");
        else begin
          ea = qa.pop_front();
          chk("rk_out_a", rk_a, ea.rk);
          chk("rk_round_a", rd_a, ea.rd);
          chk("rk_last_a", last_a, ea.last);
          got_a[ea.rd] = rk_a;
          nxfer_a++;
          if (ea.last) begin
            n_last_a = n_acc_a;
            kr_pend = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rv_b && rr_b) begin
      if (qb.size() == 0) fail_now("unexpected_rk_b");
      else begin
        eb = qb.pop_front();
        chk("rk_out_b", rk_b, eb.rk);
        chk("rk_round_b", rd_b, eb.rd);
        chk("rk_last_b", last_b, eb.last);
        got_b[eb.rd] = rk_b;
      end
    end
    if (rst && rv_c && rr_c) begin
      if (qc.size() == 0) fail_now("unexpected_rk_c");
      else begin
        ec = qc.pop_front();
        chk("rk_out_c", rk_c, ec.rk);
        chk("rk_round_c", rd_c, ec.rd);
        chk("rk_last_c", last_c, ec.last);
        got_c[ec.rd] = rk_c;
      end
    end
  end

  task automatic run_a(input logic [127:0] key, input bit rand_rdy, input bit noise, input int abort_after);
    int n;
    int base;
    for (int i = 0; i < 16; i++) got_a[i] = '0;
    n = 0;
    while (kr_a !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin fail_now("key_ready_wait_a"); return; end
    end
    kv_a = 1'b1;
    key_in_a = key;
    @(posedge clk); #1;
    kv_a = 1'b0;
    chk("key_accepted_a", kr_a, 0);
    model_push(4, {128'h0, key}, 0);
    acc_cyc = cyc;
    n_acc_a++;
    base = nxfer_a;
    n = 0;
    forever begin
      rr_a = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise && !kr_a) begin
        kv_a = 1'($urandom_range(0, 1));
        key_in_a = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        kv_a = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (n_last_a == n_acc_a) break;
      if (abort_after > 0 && nxfer_a - base >= abort_after) break;
      if (n > 3000) begin fail_now("schedule_timeout_a"); break; end
    end
    kv_a = 1'b0;
    rr_a = 1'b1;
  endtask

  task automatic run_other(input int which, input logic [255:0] key);
    int n;
    if (which == 1) begin
      for (int i = 0; i < 16; i++) got_b[i] = '0;
      key_in_b = key[191:0];
      kv_b = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) got_c[i] = '0;
      key_in_c = key;
      kv_c = 1'b1;
    end
    @(posedge clk); #1;
    kv_b = 1'b0;
    kv_c = 1'b0;
    model_push(which == 1 ? 6 : 8, key, which);
    n = 0;
    while ((which == 1 ? qb.size() : qc.size()) != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin fail_now("schedule_timeout_bc"); return; end
    end
    @(posedge clk); #1;
  endtask

  logic [127:0] rkey;

  initial begin
    build_sbox();
    kv_a = 0; kv_b = 0; kv_c = 0;
    key_in_a = '0; key_in_b = '0; key_in_c = '0;
    rr_a = 1; rr_b = 1; rr_c = 1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", kr_a, 0);
    chk("rst_rk_valid", rv_a, 0);
    chk("rst_rk_last", last_a, 0);
    chk("rst_rk_round", rd_a, 0);
    chk("rst_rk_out", rk_a, 0);
    chk("rst_rk_valid_bc", {rv_b, rv_c}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("key_ready_after_release", {kr_a, kr_b, kr_c}, 3'b111);

    fork
      run_other(1, {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b});
      run_other(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    join
    chk("k192_round12", got_b[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("k256_round14", got_c[14], 128'hfe4890d1e6188d0b046df344706c631e);
    run_other(1, {64'h0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    run_other(2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

    run_a(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 0);
    chk("k128_round0", got_a[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("k128_round1", got_a[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("k128_round10", got_a[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int k = 0; k < 3; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_a(rkey, 1'b1, 1'b1, 0);
    end
    run_a(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b1, 0);
    chk("k128_random_ready_round10", got_a[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_a(rkey, 1'b0, 1'b0, 4);
    rst = 1'b0;
    #1;
    chk("midrst_key_ready", kr_a, 0);
    chk("midrst_rk_valid", rv_a, 0);
    chk("midrst_rk_last", last_a, 0);
    chk("midrst_rk_round", rd_a, 0);
    chk("midrst_rk_out", rk_a, 0);
    qa.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_key_ready_after_release", kr_a, 1);
    chk("midrst_no_stale_valid", rv_a, 0);
    run_a(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, 0);
    chk("k128_second_round0", got_a[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("k128_second_round10", got_a[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("queue_drained", qa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
